// File: rtl/gated_bit_deserializer.sv
// Packs SEL-gated serial bits LSB-first into WIDTH-bit words and queues them in
// a 2-entry valid/ready buffer, with a sticky overflow flag and a saturating drop count.
module gated_bit_deserializer #(
   parameter int WIDTH = 8,
   parameter int BCW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN1,
   input  logic             SEL,
   input  logic             CLR,
   output logic [WIDTH-1:0] DOUT,
   output logic             DOUT_VLD,
   input  logic             DOUT_RDY,
   output logic [BCW-1:0]   BITCNT,
   output logic             OVF,
   output logic [7:0]       DROPS
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drops_q, drops_d;

   logic             acc;
   logic             last_bit;
   logic             push;
   logic             pop;
   logic             drop;
   logic             wr_en;
   logic             wr_ptr;
   logic [WIDTH-1:0] word;

   assign acc      = (SEL == 1'b0) && !CLR;
   assign last_bit = (bitcnt_q == BCW'(WIDTH - 1));
   assign word     = {IN1, shift_q[WIDTH-2:0]};

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      push     = 1'b0;
      if (CLR) begin
         state_d  = ST_IDLE;
         shift_d  = '0;
         bitcnt_d = '0;
      end else if (acc) begin
         shift_d[bitcnt_q] = IN1;
         if (last_bit) begin
            push     = 1'b1;
            state_d  = ST_IDLE;
            shift_d  = '0;
            bitcnt_d = '0;
         end else begin
            state_d  = ST_SHIFT;
            bitcnt_d = bitcnt_q + BCW'(1);
         end
      end
   end

   // A full buffer still accepts a push when the head leaves on the same edge.
   assign pop    = DOUT_VLD && DOUT_RDY;
   assign drop   = push && (occ_q == 2'd2) && !pop;
   assign wr_en  = push && !drop;
   assign wr_ptr = rd_ptr_q ^ occ_q[0];

   always_comb begin
      occ_d    = occ_q + {1'b0, wr_en} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      ovf_d    = ovf_q;
      drops_d  = drops_q;
      if (CLR) begin
         ovf_d = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
      end
      if (drop && (drops_q != 8'hFF)) begin
         drops_d = drops_q + 8'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         ovf_q    <= 1'b0;
         drops_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
         drops_q  <= drops_d;
      end
   end

   // NOTE: the storage array is not reset; DOUT is masked by occupancy, so stale contents never show.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= word;
      end
   end

   assign DOUT_VLD = (occ_q != 2'd0);
   assign DOUT     = DOUT_VLD ? mem_q[rd_ptr_q] : '0;
   assign BITCNT   = bitcnt_q;
   assign OVF      = ovf_q;
   assign DROPS    = drops_q;

endmodule

// File: tb/tb_gated_bit_deserializer.sv
// Self-checking bench for gated_bit_deserializer: table vectors, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_gated_bit_deserializer;

   localparam int WIDTH = 8;
   localparam int BCW   = 3;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             IN1, SEL, CLR, DOUT_RDY;
   logic [WIDTH-1:0] DOUT;
   logic             DOUT_VLD;
   logic [BCW-1:0]   BITCNT;
   logic             OVF;
   logic [7:0]       DROPS;

   int n_checks = 0;
   int n_errors = 0;

   gated_bit_deserializer #(.WIDTH(WIDTH), .BCW(BCW)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN1(IN1), .SEL(SEL), .CLR(CLR),
      .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY),
      .BITCNT(BITCNT), .OVF(OVF), .DROPS(DROPS)
   );

   always #5 CLK = ~CLK;

   // Reference model: words are values in a queue, the partial word is an integer.
   logic [7:0] m_q[$];
   logic [7:0] m_part;
   int         m_cnt;
   bit         m_ovf;
   int         m_drops;

   task automatic model_reset();
      m_q.delete();
      m_part  = 8'd0;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   task automatic model_step(input logic sel, input logic in1, input logic clr, input logic rdy);
      bit         pop, push;
      logic [7:0] w;
      pop  = (m_q.size() != 0) && rdy;
      push = 1'b0;
      w    = 8'd0;
      if (clr) begin
         m_part = 8'd0;
         m_cnt  = 0;
         m_ovf  = 1'b0;
      end else if (sel == 1'b0) begin
         m_part = m_part | (8'(in1) << m_cnt);
         m_cnt++;
         if (m_cnt == WIDTH) begin
            push   = 1'b1;
            w      = m_part;
            m_part = 8'd0;
            m_cnt  = 0;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < 2) m_q.push_back(w);
         else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, " vld"},    32'(DOUT_VLD), 32'(m_q.size() != 0));
      check({tag, " dout"},   32'(DOUT),     (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check({tag, " bitcnt"}, 32'(BITCNT),   32'(m_cnt));
      check({tag, " ovf"},    32'(OVF),      32'(m_ovf));
      check({tag, " drops"},  32'(DROPS),    32'(m_drops));
   endtask

   // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
   task automatic apply(input logic sel, input logic in1, input logic clr, input logic rdy);
      SEL = sel; IN1 = in1; CLR = clr; DOUT_RDY = rdy;
      @(posedge CLK);
      #1;
      model_step(sel, in1, clr, rdy);
   endtask

   task automatic send_word(input logic [7:0] w, input logic rdy);
      for (int i = 0; i < WIDTH; i++) apply(1'b0, w[i], 1'b0, rdy);
   endtask

   typedef struct packed {
      logic       sel, in1, clr, rdy;
      logic       exp_vld;
      logic [7:0] exp_dout;
      logic [2:0] exp_bitcnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic sel, input logic in1, input logic rdy,
                          input logic vld, input logic [7:0] dout, input logic [2:0] bc);
      vec_t v;
      v.sel = sel; v.in1 = in1; v.clr = 1'b0; v.rdy = rdy;
      v.exp_vld = vld; v.exp_dout = dout; v.exp_bitcnt = bc;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] stream;
      logic [7:0] w;
      stream = 8'h85;

      // Plain word, then its pop.
      for (int i = 0; i < 8; i++)
         add_vec(1'b0, stream[i], 1'b1, i == 7, (i == 7) ? 8'h85 : 8'h00, 3'((i + 1) % 8));
      add_vec(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
      // Same stream with SEL high for three cycles after the fourth bit.
      for (int i = 0; i < 4; i++) add_vec(1'b0, stream[i], 1'b1, 1'b0, 8'h00, 3'(i + 1));
      for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'd4);
      for (int i = 4; i < 8; i++)
         add_vec(1'b0, stream[i], 1'b1, i == 7, (i == 7) ? 8'h85 : 8'h00, 3'((i + 1) % 8));
      add_vec(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);

      SEL = 1'b1; IN1 = 1'b0; CLR = 1'b0; DOUT_RDY = 1'b0;
      RST_N = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      check("reset vld", 32'(DOUT_VLD), 32'd0);
      check("reset dout", 32'(DOUT), 32'd0);
      check("reset bitcnt", 32'(BITCNT), 32'd0);
      check("reset ovf", 32'(OVF), 32'd0);
      check("reset drops", 32'(DROPS), 32'd0);

      foreach (vecs[i]) begin
         apply(vecs[i].sel, vecs[i].in1, vecs[i].clr, vecs[i].rdy);
         check($sformatf("vec%0d vld", i), 32'(DOUT_VLD), 32'(vecs[i].exp_vld));
         check($sformatf("vec%0d dout", i), 32'(DOUT), 32'(vecs[i].exp_dout));
         check($sformatf("vec%0d bitcnt", i), 32'(BITCNT), 32'(vecs[i].exp_bitcnt));
      end

      // Overflow: three words with the consumer stalled.
      send_word(8'h11, 1'b0);
      check("ovf w1 dout", 32'(DOUT), 32'h11);
      send_word(8'h22, 1'b0);
      check("ovf w2 head stable", 32'(DOUT), 32'h11);
      check("ovf w2 no drop", 32'(OVF), 32'd0);
      send_word(8'h33, 1'b0);
      check("ovf head", 32'(DOUT), 32'h11);
      check("ovf flag", 32'(OVF), 32'd1);
      check("ovf drops", 32'(DROPS), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check("ovf pop1 dout", 32'(DOUT), 32'h22);
      check("ovf pop1 vld", 32'(DOUT_VLD), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check("ovf pop2 vld", 32'(DOUT_VLD), 32'd0);

      // CLR while OVF is set clears it and keeps the drop count.
      apply(1'b1, 1'b0, 1'b1, 1'b0);
      check("clr ovf", 32'(OVF), 32'd0);
      check("clr drops", 32'(DROPS), 32'd1);

      // Third word completes on the same edge as a pop at occupancy 2.
      send_word(8'hA1, 1'b0);
      send_word(8'hA2, 1'b0);
      w = 8'hA3;
      for (int i = 0; i < 8; i++) apply(1'b0, w[i], 1'b0, i == 7);
      check("pp2 dout", 32'(DOUT), 32'hA2);
      check("pp2 vld", 32'(DOUT_VLD), 32'd1);
      check("pp2 ovf", 32'(OVF), 32'd0);
      check("pp2 drops", 32'(DROPS), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check("pp2 pop dout", 32'(DOUT), 32'hA3);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check("pp2 empty", 32'(DOUT_VLD), 32'd0);

      // Partial word discarded by CLR.
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 1'b1);
      check("clr pre bitcnt", 32'(BITCNT), 32'd5);
      apply(1'b0, 1'b1, 1'b1, 1'b1);
      check("clr bitcnt", 32'(BITCNT), 32'd0);
      send_word(8'hF0, 1'b1);
      check("clr word", 32'(DOUT), 32'hF0);
      check("clr word vld", 32'(DOUT_VLD), 32'd1);
      apply(1'b1, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-word with one word buffered.
      send_word(8'h5A, 1'b0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 1'b0);
      SEL = 1'b1;
      #3;
      RST_N = 1'b0;
      #1;
      check("arst vld", 32'(DOUT_VLD), 32'd0);
      check("arst dout", 32'(DOUT), 32'd0);
      check("arst bitcnt", 32'(BITCNT), 32'd0);
      check("arst ovf", 32'(OVF), 32'd0);
      check("arst drops", 32'(DROPS), 32'd0);
      model_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      send_word(8'h3C, 1'b0);
      check("arst next word", 32'(DOUT), 32'h3C);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check_model("arst drain");

      // Drop counter saturation.
      for (int i = 0; i < 260; i++) send_word(8'($urandom), 1'b0);
      check("sat drops", 32'(DROPS), 32'd255);
      check("sat ovf", 32'(OVF), 32'd1);
      check_model("sat");
      apply(1'b1, 1'b0, 1'b1, 1'b1);
      apply(1'b1, 1'b0, 1'b0, 1'b1);
      check_model("sat drain");

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         apply($urandom_range(0, 9) < 3, 1'($urandom), $urandom_range(0, 49) == 0,
               $urandom_range(0, 9) < 4);
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gated_bit_deserializer.md
# gated_bit_deserializer

Downstream stage of the SEL-gated bit path. It samples the serial bit IN1 on every clock edge where the select SEL is 0, which is the gate-open condition of the upstream select function. It packs accepted bits LSB-first into WIDTH-bit words and queues the finished words in a 2-entry output buffer drained over a valid/ready handshake. Overflow is reported by a sticky flag and a saturating drop counter.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- BCW, $clog2(WIDTH), width of the bit-count field.

Ports:
- CLK  input  1  single clock; every register updates on the rising edge.
- RST_N  input  1  reset; **one clock; reset is asynchronous and active-low**.
- IN1  input  1  serial data bit from the gated stage.
- SEL  input  1  select; a bit is accepted only when SEL==0; any nonzero SEL blocks.
- CLR  input  1  synchronous clear of the partial word and of OVF.
- DOUT  output  WIDTH  head word of the buffer; all zeros when the buffer is empty.
- DOUT_VLD  output  1  buffer is non-empty.
- DOUT_RDY  input  1  consumer accepts the head word.
- BITCNT  output  BCW  number of bits held in the partial word.
- OVF  output  1  sticky flag; set when a completed word is dropped.
- DROPS  output  8  count of dropped words; saturates at 255.

## Operation
- Reset (RST_N low, asynchronous):
  - shift register = 0, BITCNT = 0, collector state IDLE;
  - buffer emptied, so DOUT = 0 and DOUT_VLD = 0;
  - OVF = 0, DROPS = 0.
- Accept condition: acc = (SEL==0) && !CLR.
  - On acc, IN1 is written to shift bit BITCNT; the first accepted bit lands in bit 0.
  - When SEL!=0, IN1 is ignored and all collector state holds.
- Collector FSM:
  - IDLE → SHIFT on acc; BITCNT becomes 1.
  - SHIFT → SHIFT on acc with BITCNT < WIDTH-1; BITCNT increments.
  - SHIFT → IDLE on acc with BITCNT == WIDTH-1. The completed word is {IN1, shift[WIDTH-2:0]}. It is pushed to the buffer and BITCNT returns to 0.
  - CLR from any state → IDLE. BITCNT = 0, shift = 0, OVF = 0. DROPS and the buffer are unaffected.
- Buffer: 2-entry FIFO with occupancy 0..2.
  - pop = DOUT_VLD && DOUT_RDY.
  - push = word completion.
- Push with occupancy 2 and no pop in the same cycle: the new word is dropped, OVF is set, and DROPS increments unless it is already 255.
- Push and pop in the same cycle at occupancy 2: the push is accepted, no drop occurs, and occupancy stays 2.
- Push and pop in the same cycle at occupancy 1: the pushed word becomes the head; occupancy stays 1.
- Pop at occupancy 0 is impossible, because DOUT_VLD is low.
- Ordering is FIFO; words are never reordered.

## Timing
- Every output is registered or decoded from registers only. There is no combinational path from any input to any output.
- Latency: the edge that accepts the last bit of a word also writes the buffer. DOUT_VLD and DOUT are valid right after that edge when the buffer was empty.
- Throughput: one bit per cycle. A word can complete at most every WIDTH cycles, so the buffer never overflows if DOUT_RDY is held high.
- Handshake rules:
  - DOUT and DOUT_VLD stay stable while DOUT_VLD=1 and DOUT_RDY=0.
  - The head advances on the edge where pop occurs.
- An asynchronous RST_N assertion in the middle of a word discards the partial word and the buffered words. The first accepted bit after release goes to bit 0.
- RST_N deassertion is assumed to be synchronized externally; no internal synchronizer.

## Test plan
- Reset, then SEL=0 and DOUT_RDY=1, driving IN1 = 1,0,1,0,0,0,0,1 on 8 consecutive cycles → DOUT=8'h85 with DOUT_VLD=1 after the 8th edge; DOUT_VLD drops on the next edge.
- Same bit stream as the previous test, with SEL=1 for 3 cycles after the 4th bit → BITCNT holds at 4 through those 3 cycles; the final word is still 8'h85, 3 cycles later.
- DOUT_RDY=0, with three words 8'h11, 8'h22, 8'h33 sent back-to-back → DOUT stays 8'h11, OVF=1, and DROPS=1. With DOUT_RDY=1 afterwards, 8'h11 then 8'h22 are popped, then DOUT_VLD=0.
- Occupancy 2 with the third word completing on the same edge as a pop (DOUT_RDY=1) → no drop and OVF stays 0. Pops return the three words in order.
- 5 bits accepted, then a CLR pulse, then 8 bits of 8'hF0 → output is 8'hF0 with no leftover bits. A CLR pulse while OVF=1 clears OVF but leaves DROPS unchanged.
- RST_N pulsed low asynchronously mid-word with 1 word buffered → DOUT_VLD, BITCNT, OVF and DROPS are all 0 immediately, with no clock edge needed.
